// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end feeding a single shared ALU with one result register.
// Latency: an operation granted in cycle k has rsp_valid high from cycle k+2; the minimum issue interval is 3 cycles.
// Backpressure: the result holds in DONE until rsp_ready is high, and no new request is granted until then.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   reqX_valid/ready          per-requester handshake (X = 0, 1); ready is combinational and only asserted in IDLE
//   reqX_op, reqX_a, reqX_b   opcode and N-bit operands
//   rsp_valid/ready           result handshake
//   rsp_id, rsp_result, rsp_err  issuing requester, result, illegal-opcode flag
module alu_rr_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic         rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;

    state_t       r_state;
    logic         r_last_grant;
    logic         r_id;
    logic [2:0]   r_op;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;

    logic         w_grant;
    logic         w_grant_id;
    logic [2:0]   w_sel_op;
    logic [N-1:0] w_sel_a;
    logic [N-1:0] w_sel_b;

    logic [N:0]   w_sub_ext;
    logic [N-1:0] w_diff;
    logic         w_borrow;
    logic         w_ovf;
    logic         w_slt;
    logic [N-1:0] w_result;
    logic         w_err;

    // On a tie the requester that did not win last time gets the grant;
    // a lone requester always wins.
    always_comb begin
        w_grant_id = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
        w_grant    = (r_state == S_IDLE) && !rst && (req0_valid || req1_valid);
    end

    assign req0_ready = w_grant && !w_grant_id;
    assign req1_ready = w_grant &&  w_grant_id;

    assign w_sel_op = w_grant_id ? req1_op : req0_op;
    assign w_sel_a  = w_grant_id ? req1_a  : req0_a;
    assign w_sel_b  = w_grant_id ? req1_b  : req0_b;

    // One N+1-bit subtract serves SUB, SLT and SLTU: the extra top bit is the
    // unsigned borrow, and signed less-than is sign(diff) corrected by overflow.
    assign w_sub_ext = {1'b0, r_a} - {1'b0, r_b};
    assign w_diff    = w_sub_ext[N-1:0];
    assign w_borrow  = w_sub_ext[N];
    assign w_ovf     = (r_a[N-1] ^ r_b[N-1]) & (w_diff[N-1] ^ r_a[N-1]);
    assign w_slt     = w_diff[N-1] ^ w_ovf;

    always_comb begin
        w_result = '0;
        w_err    = 1'b0;
        case (r_op)
            OP_ADD:  w_result = r_a + r_b;
            OP_SUB:  w_result = w_diff;
            OP_AND:  w_result = r_a & r_b;
            OP_OR:   w_result = r_a | r_b;
            OP_SLT:  w_result = {{(N-1){1'b0}}, w_slt};
            OP_SLTU: w_result = {{(N-1){1'b0}}, w_borrow};
            default: w_err    = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_id         <= w_grant_id;
                        r_op         <= w_sel_op;
                        r_a          <= w_sel_a;
                        r_b          <= w_sel_b;
                        r_last_grant <= w_grant_id;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_result <= w_result;
                    rsp_err    <= w_err;
                    rsp_id     <= r_id;
                    rsp_valid  <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: scoreboard of expected results pushed at grant, popped at consumption.
// Latency: checks rsp_valid exactly two cycles after each grant and a 3-cycle issue interval.
// Backpressure: holds rsp_ready low and checks that outputs stay stable and no requester is granted.
module tb_alu_rr_arbiter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [2:0]   req0_op = '0, req1_op = '0;
    logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_id;
    logic [N-1:0] rsp_result;
    logic         rsp_err;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // {id, err, result}
    logic [33:0] sb[$];
    logic [33:0] hist[$];

    int   m_st      = 0;      // 0 idle, 1 exec, 2 done: state the DUT is in this cycle
    logic m_last    = 1'b1;
    int   n_grant   = 0;
    int   n_rsp     = 0;
    logic last_gid  = 1'b0;
    int   last_gcyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] model(input logic id, input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        e;
        r = 32'h0;
        e = 1'b0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5: r = (a < b) ? 32'd1 : 32'd0;
            default: e = 1'b1;
        endcase
        return {id, e, r};
    endfunction

    // Reference model of arbitration and the result pipeline, evaluated
    // mid-cycle; m_st is advanced to describe the following cycle.
    always @(negedge clk) begin : monitor
        logic e0, e1, win;
        if (rst) begin
            chk("rst_rdy0", req0_ready, 0);
            chk("rst_rdy1", req1_ready, 0);
            m_st   = 0;
            m_last = 1'b1;
            sb.delete();
        end else begin
            e0 = 1'b0; e1 = 1'b0; win = 1'b0;
            if (m_st == 0 && (req0_valid || req1_valid)) begin
                win = (req0_valid && req1_valid) ? ~m_last : req1_valid;
                e0  = ~win;
                e1  = win;
            end
            chk("rdy0", req0_ready, e0);
            chk("rdy1", req1_ready, e1);
            case (m_st)
                0: begin
                    chk("idle_vld", rsp_valid, 0);
                    if (e0 || e1) begin
                        if (win) sb.push_back(model(1'b1, req1_op, req1_a, req1_b));
                        else     sb.push_back(model(1'b0, req0_op, req0_a, req0_b));
                        m_last    = win;
                        last_gid  = win;
                        last_gcyc = cyc;
                        n_grant++;
                        m_st = 1;
                    end
                end
                1: begin
                    chk("exec_vld", rsp_valid, 0);
                    m_st = 2;
                end
                default: begin
                    chk("done_vld", rsp_valid, 1);
                    chk("sb_depth", sb.size(), 1);
                    if (sb.size() > 0) begin
                        chk("rsp", {rsp_id, rsp_err, rsp_result}, sb[0]);
                        if (rsp_ready) begin
                            hist.push_back({rsp_id, rsp_err, rsp_result});
                            void'(sb.pop_front());
                            n_rsp++;
                            m_st = 0;
                        end
                    end
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int target, input int budget);
        for (int i = 0; i < budget && n_grant < target; i++) step();
        if (n_grant < target) chk("grant_timeout", n_grant, target);
    endtask

    task automatic wait_rsps(input int target, input int budget);
        for (int i = 0; i < budget && n_rsp < target; i++) step();
        if (n_rsp < target) chk("rsp_timeout", n_rsp, target);
    endtask

    task automatic set_req(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id) begin req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_op = op; req0_a = a; req0_b = b; end
    endtask

    // Single operation from one requester, with an explicit expected result.
    task automatic issue(input string tag, input logic id, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_err);
        int g0, r0;
        g0 = n_grant;
        r0 = n_rsp;
        set_req(id, op, a, b);
        if (id) req1_valid = 1'b1; else req0_valid = 1'b1;
        wait_grants(g0 + 1, 20);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsps(r0 + 1, 20);
        if (hist.size() > 0) chk(tag, hist[$], {id, exp_err, exp_res});
    endtask

    initial begin : stim
        int g0, r0, k, prev;
        // Tie straight out of reset: both requesters valid from cycle 0.
        set_req(1'b0, 3'd0, 32'd5, 32'd7);
        set_req(1'b1, 3'd1, 32'd3, 32'd5);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        step();
        step();
        chk("reset_vld", rsp_valid, 0);
        chk("reset_id", rsp_id, 0);
        chk("reset_err", rsp_err, 0);
        chk("reset_res", rsp_result, 0);
        rst = 1'b0;
        wait_grants(1, 10);
        chk("tie_first", last_gid, 0);
        req0_valid = 1'b0;
        wait_grants(2, 10);
        chk("tie_second", last_gid, 1);
        req1_valid = 1'b0;
        wait_rsps(2, 10);
        if (hist.size() >= 2) begin
            chk("tie_rsp0", hist[0], {1'b0, 1'b0, 32'd12});
            chk("tie_rsp1", hist[1], {1'b1, 1'b0, 32'hFFFF_FFFE});
        end

        // Signed versus unsigned compare, including the overflow case.
        issue("slt_neg",  1'b0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        issue("sltu_big", 1'b1, 3'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        issue("slt_ovf",  1'b0, 3'd4, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0);
        issue("and_op",   1'b1, 3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0);

        // Backpressure: result held for 5 cycles while both requesters wait.
        rsp_ready = 1'b0;
        g0 = n_grant;
        set_req(1'b0, 3'd3, 32'hA000_0005, 32'h0500_0030);
        req0_valid = 1'b1;
        wait_grants(g0 + 1, 10);
        req1_valid = 1'b1;
        for (int i = 0; i < 10 && !rsp_valid; i++) step();
        chk("bp_rsp_seen", rsp_valid, 1);
        repeat (5) step();
        chk("bp_no_grant", n_grant, g0 + 1);
        r0 = n_rsp;
        rsp_ready  = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) step();
        chk("bp_single", n_rsp, r0 + 1);
        if (hist.size() > 0) chk("bp_rsp", hist[$], {1'b0, 1'b0, 32'hA500_0035});

        // Illegal opcode, then a legal one clears the error flag.
        issue("illegal", 1'b1, 3'd7, 32'h1234_5678, 32'h1, 32'd0, 1'b1);
        issue("illegal6", 1'b0, 3'd6, 32'h5, 32'h1, 32'd0, 1'b1);
        issue("legal_after", 1'b1, 3'd0, 32'd2, 32'd3, 32'd5, 1'b0);

        // Reset while in EXEC after a req0 grant abandons the operation and
        // restores req0 priority on the next tie.
        g0 = n_grant;
        r0 = n_rsp;
        set_req(1'b0, 3'd0, 32'd1, 32'd1);
        req0_valid = 1'b1;
        wait_grants(g0 + 1, 10);
        req0_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();
        chk("rst_no_rsp", n_rsp, r0);
        chk("rst_vld_low", rsp_valid, 0);
        g0 = n_grant;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_grants(g0 + 1, 10);
        chk("rst_tie", last_gid, 0);
        req0_valid = 1'b0;
        wait_grants(g0 + 2, 10);
        req1_valid = 1'b0;
        wait_rsps(r0 + 2, 10);

        // Fairness: both valid continuously, operands change every cycle so
        // in-flight results must come from the values latched at grant.
        r0 = n_rsp;
        g0 = n_grant;
        k = 0;
        prev = 0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int c = 0; c < 60 && k < 10; c++) begin
            set_req(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
            set_req(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
            step();
            if (n_grant != g0 + k) begin
                chk("fair_gid", last_gid, k % 2);
                if (k > 0) chk("fair_gap", last_gcyc - prev, 3);
                prev = last_gcyc;
                k++;
            end
        end
        chk("fair_count", k, 10);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsps(r0 + 10, 20);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
